// File: rtl/seg7_out.sv
// seg7_out: CPU-mapped 4-digit 7-segment and LED output port, I/O window 0xF0-0xF5.
// Optional blink blanking via CTRL bit1 is built only when SEG7_BLINK_EN is defined.
module seg7_out #(
  parameter int SCAN_BITS  = 16,
  parameter int BLINK_BITS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [7:0] led,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [7:0] ADDR_LED  = 8'hF4;
  localparam logic [7:0] ADDR_CTRL = 8'hF5;

  logic [3:0][4:0]       digit_q, digit_d;
  logic [7:0]            led_q, led_d;
  logic                  en_q, en_d;
  logic [SCAN_BITS-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [3:0]            an_q, an_d;
  logic                  sel_digit;
  logic                  blank;
  logic                  ctrl_blink_rd;
  logic [4:0]            cur_digit;

`ifdef SEG7_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic                  blink_q, blink_d;
`else
  logic                  unused_blink_bits;
  assign unused_blink_bits = (BLINK_BITS > 0);
`endif

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] dec(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign sel_digit = (addr[7:2] == 6'b111100);

  always_comb begin
    digit_d    = digit_q;
    led_d      = led_q;
    en_d       = en_q;
    scan_cnt_d = scan_cnt_q + SCAN_BITS'(1);
    idx_d      = (&scan_cnt_q) ? idx_q + 2'd1 : idx_q;
    if (we && sel_digit)          digit_d[addr[1:0]] = wdata[4:0];
    if (we && addr == ADDR_LED)   led_d = wdata;
    if (we && addr == ADDR_CTRL)  en_d = wdata[0];
  end

`ifdef SEG7_BLINK_EN
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
    phase_d     = (&blink_cnt_q) ? ~phase_q : phase_q;
    blink_d     = (we && addr == ADDR_CTRL) ? wdata[1] : blink_q;
  end
  assign ctrl_blink_rd = blink_q;
  assign blank         = ~en_q | (blink_q & phase_q);
`else
  assign ctrl_blink_rd = 1'b0;
  assign blank         = ~en_q;
`endif

  // Output stage registers the digit chosen by the current idx, so seg/an trail idx by one edge.
  always_comb begin
    cur_digit = digit_q[idx_q];
    an_d      = 4'hF;
    seg_d     = 8'hFF;
    if (!blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~cur_digit[4], dec(cur_digit[3:0])};
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (sel_digit)              rdata = {3'b000, digit_q[addr[1:0]]};
    else if (addr == ADDR_LED)  rdata = led_q;
    else if (addr == ADDR_CTRL) rdata = {6'b000000, ctrl_blink_rd, en_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q     <= '0;
      led_q       <= 8'h00;
      en_q        <= 1'b1;
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      seg_q       <= 8'hFF;
      an_q        <= 4'hF;
`ifdef SEG7_BLINK_EN
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blink_q     <= 1'b0;
`endif
    end else begin
      digit_q     <= digit_d;
      led_q       <= led_d;
      en_q        <= en_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
`ifdef SEG7_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blink_q     <= blink_d;
`endif
    end
  end

  assign led = led_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_out.sv
// Self-checking bench for seg7_out with SCAN_BITS=2, BLINK_BITS=3.
`timescale 1ns/1ps
module tb_seg7_out;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic       we    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata, led, seg;
  logic [3:0] an;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] wd;
    logic [7:0] seg;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } rd_exp_t;

  rd_exp_t sb[$];

  seg7_out #(.SCAN_BITS(2), .BLINK_BITS(3)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .led(led), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Called at a negedge; store is captured at the next posedge, returns at the following negedge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd_exp);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    addr  = 8'h00;
    sb.push_back('{a, rd_exp});
  endtask

  task automatic drain();
    rd_exp_t e;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      addr = e.a;
      #1;
      check($sformatf("rd_%0h", e.a), rdata, e.d);
    end
    addr = 8'h00;
  endtask

  task automatic wait_an(input logic [3:0] t, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (an === t) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    timeout($sformatf("wait_an_%0h", t));
  endtask

  task automatic wait_an_not(input logic [3:0] t, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (an !== t) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    timeout($sformatf("wait_an_not_%0h", t));
  endtask

  // Number of negedges the current an value persists (bounded).
  task automatic hold_len(output int h);
    logic [3:0] cur;
    cur = an;
    h   = 0;
    while (an === cur && h < 40) begin
      @(negedge clk);
      h++;
    end
  endtask

  initial begin
    vec_t       vecs [19];
    logic [3:0] exp_an [5];
    logic [7:0] exp_sg [5];
    bit         ok;
    int         h;
    int         bad;

    vecs[0]  = '{8'h00, 8'hC0, 8'h00};
    vecs[1]  = '{8'h01, 8'hF9, 8'h01};
    vecs[2]  = '{8'h02, 8'hA4, 8'h02};
    vecs[3]  = '{8'h03, 8'hB0, 8'h03};
    vecs[4]  = '{8'h04, 8'h99, 8'h04};
    vecs[5]  = '{8'h05, 8'h92, 8'h05};
    vecs[6]  = '{8'h06, 8'h82, 8'h06};
    vecs[7]  = '{8'h07, 8'hF8, 8'h07};
    vecs[8]  = '{8'h08, 8'h80, 8'h08};
    vecs[9]  = '{8'h09, 8'h90, 8'h09};
    vecs[10] = '{8'h0A, 8'h88, 8'h0A};
    vecs[11] = '{8'h0B, 8'h83, 8'h0B};
    vecs[12] = '{8'h0C, 8'hC6, 8'h0C};
    vecs[13] = '{8'h0D, 8'hA1, 8'h0D};
    vecs[14] = '{8'h0E, 8'h86, 8'h0E};
    vecs[15] = '{8'h0F, 8'h8E, 8'h0F};
    vecs[16] = '{8'h10, 8'h40, 8'h10};
    vecs[17] = '{8'hFA, 8'h08, 8'h1A};
    vecs[18] = '{8'hE5, 8'h92, 8'h05};

    exp_an[0] = 4'hE; exp_sg[0] = 8'h79;
    exp_an[1] = 4'hD; exp_sg[1] = 8'hA4;
    exp_an[2] = 4'hB; exp_sg[2] = 8'h30;
    exp_an[3] = 4'h7; exp_sg[3] = 8'hC6;
    exp_an[4] = 4'hE; exp_sg[4] = 8'h79;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_led", led, 8'h00);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 8'hFF);
    sb.push_back('{8'hF5, 8'h01});
    drain();
    rst = 1'b0;
    @(negedge clk);
    check("first_an", an, 4'hE);
    check("first_seg", seg, 8'hC0);

    // LED register
    wr(8'hF4, 8'hA5, 8'hA5);
    check("led_after_store", led, 8'hA5);
    drain();

    // Decoder table through digit 0
    foreach (vecs[i]) begin
      wr(8'hF0, vecs[i].wd, vecs[i].rd);
      @(negedge clk);
      wait_an(4'hE, 20, ok);
      if (ok) check($sformatf("dec_%0d", i), seg, vecs[i].seg);
      drain();
    end

    // Digit 1 readback and out-of-window reads
    wr(8'hF1, 8'h1A, 8'h1A);
    @(negedge clk);
    wait_an(4'hD, 20, ok);
    if (ok) check("d1_seg", seg, 8'h08);
    sb.push_back('{8'hF6, 8'h00});
    sb.push_back('{8'hEF, 8'h00});
    drain();

    // Scan order and dwell with four distinct digits
    wr(8'hF0, 8'h11, 8'h11);
    wr(8'hF1, 8'h02, 8'h02);
    wr(8'hF2, 8'h13, 8'h13);
    wr(8'hF3, 8'h0C, 8'h0C);
    drain();
    @(negedge clk);
    wait_an(4'h7, 20, ok);
    wait_an_not(4'h7, 20, ok);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("scan_an_%0d", k), an, exp_an[k]);
      check($sformatf("scan_seg_%0d", k), seg, exp_sg[k]);
      if (k < 4) begin
        hold_len(h);
        check($sformatf("scan_hold_%0d", k), h, 4);
      end
    end

    // Display enable off/on
    wr(8'hF5, 8'h00, 8'h00);
    check("en_off_edge1_active", (an !== 4'hF), 1);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (an !== 4'hF || seg !== 8'hFF) bad++;
      @(negedge clk);
    end
    check("en_off_blank_cycles", bad, 0);
    drain();
    wr(8'hF5, 8'h01, 8'h01);
    @(negedge clk);
    check("en_on_onecold", (an == 4'hE || an == 4'hD || an == 4'hB || an == 4'h7), 1);
    drain();

`ifdef SEG7_BLINK_EN
    wr(8'hF5, 8'h03, 8'h03);
    drain();
    wait_an_not(4'hF, 40, ok);
    wait_an(4'hF, 40, ok);
    check("blink_led", led, 8'hA5);
    check("blink_seg_blank", seg, 8'hFF);
    hold_len(h);
    check("blink_blank_len", h, 8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (an === 4'hF) bad++;
      @(negedge clk);
    end
    check("blink_active_len", bad, 0);
    check("blink_reblank", an, 4'hF);
`else
    wr(8'hF5, 8'h03, 8'h01);
    drain();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (an === 4'hF) bad++;
      @(negedge clk);
    end
    check("no_blink_blanks", bad, 0);
`endif
    wr(8'hF5, 8'h01, 8'h01);
    drain();

    // Asynchronous reset mid-scan at idx=2
    wait_an(4'hB, 40, ok);
    rst = 1'b1;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 8'hFF);
    check("arst_led", led, 8'h00);
    for (int i = 0; i < 4; i++) sb.push_back('{8'hF0 + 8'(i), 8'h00});
    sb.push_back('{8'hF4, 8'h00});
    sb.push_back('{8'hF5, 8'h01});
    drain();
    @(negedge clk);
    @(negedge clk);
    check("arst_hold_an", an, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    check("restart_an", an, 4'hE);
    check("restart_seg", seg, 8'hC0);
    hold_len(h);
    check("restart_hold", h, 4);
    check("restart_next_an", an, 4'hD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_out.md
# seg7_out

Memory-mapped output peripheral that the CPU drives with stores. It holds four hex-digit registers, an 8-bit LED register and a control register. It time-multiplexes the digits onto a common-anode 4-digit 7-segment display. It sits on the same 8-bit I/O address bus as the push-button input, in the 0xF0–0xF5 window, and its read data is OR-combined with the other peripherals' outputs.

## Interface
Parameters:
- SCAN_BITS, 16: digit advance period is 2^SCAN_BITS clocks.
- BLINK_BITS, 24: blink phase toggles every 2^BLINK_BITS clocks. Used only with SEG7_BLINK_EN.

Ports:
- clk, in, 1: system clock; all state on rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- addr, in, 8: I/O address.
- we, in, 1: write strobe, one cycle per store.
- wdata, in, 8: store data.
- rdata, out, 8: combinational read data; 8'h00 when addr is outside 0xF0–0xF5.
- led, out, 8: LED register, active-high.
- seg, out, 8: segments, active-low, {dp,g,f,e,d,c,b,a}.
- an, out, 4: digit anodes, active-low, an[i] drives digit i.

## Operation
- Register map, each written when we=1 and addr matches; effect is visible the next cycle:
  - 0xF0–0xF3, DIGITi: 5 bits. bit4 is dp, bits3:0 are hex value. wdata[7:5] is ignored; those bits read as 0.
  - 0xF4, LED: 8 bits, drives led directly from the register.
  - 0xF5, CTRL: bit0 EN (display enable), bit1 BLINK. Other bits are ignored and read as 0.
- Reset values: DIGIT0–3=0, LED=0, CTRL=8'h01, scan counter=0, idx=0, blink counter=0, blink phase=0. Outputs at reset: seg=8'hFF, an=4'hF, led=8'h00.
- Scan counter is SCAN_BITS wide and increments every cycle.
  - When it equals all-ones, idx (2 bits) increments and wraps 3→0.
  - Scanning runs regardless of EN.
- Registered output stage, every cycle:
  - If the display is blanked (EN=0, or blink-blank active): an<=4'hF, seg<=8'hFF.
  - Otherwise: an<=~(4'b0001<<idx), seg<={~dp, dec(hex)} from DIGIT[idx].
- dec, active-low {g..a}:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Exactly one anode is low at any time while the display is not blanked.
- rdata returns the current register contents for the matching address. It reflects a write starting the cycle after the store.

## Timing
- Write to display latency:
  - Store at cycle N updates the register at edge N+1.
  - seg/an reflect it at edge N+2, provided idx selects that digit.
- Digit change: idx changes at the edge where the counter wraps; seg/an follow one cycle later.
- Full refresh period is 4·2^SCAN_BITS clocks.
- Write in the same cycle as an idx advance: both take effect. The output at the next-next edge shows the new idx with the new data.
- Writes to 0xF0–0xF5 never stall and never disturb the scan counter.
- rst asserted mid-scan: all state returns to reset values immediately, without waiting for a clock. The scan restarts from idx=0.
- While rst is high, outputs hold the reset values.

## Configuration
- SEG7_BLINK_EN defined:
  - A BLINK_BITS-wide counter runs, and the blink phase toggles at each wrap.
  - When CTRL.BLINK=1 and phase=1, the display is blanked (an=4'hF, seg=8'hFF).
  - The LED outputs never blink.
- SEG7_BLINK_EN undefined:
  - No blink counter is built.
  - CTRL bit1 is not stored and reads as 0.
  - The display is blanked only by EN=0.

## Test plan
- Reset with SCAN_BITS=2 → led=00, an=F, seg=FF while rst=1; CTRL reads 01; first non-blank output after release is an=E, seg=C0.
- Store 0xF1←0x1A, then wait for idx=1 → an=D, seg=08; read of 0xF1 returns 1A; read of 0xF6 returns 00.
- SCAN_BITS=2, all digits distinct → an sequence E,D,B,7,E, each held exactly 4 cycles.
- Store 0xF5←0x00 → an=F, seg=FF from the second edge after the store; store 0xF5←0x01 restores scanning at the current idx.
- SEG7_BLINK_EN with BLINK_BITS=3, CTRL=03 → display alternates 8 cycles active, 8 cycles blank; led is unaffected. Without the macro, CTRL←03 reads back 01 and there is no blanking.
- Assert rst mid-scan at idx=2 → an=F immediately; after release the scan restarts at idx=0 and all registers read their reset values.
